// File: rtl/gpio_pkg.sv
// ---------------------------------------------------------------------------
// gpio_pkg
// Shared definitions for the GPIO input capture front end.
//   - edge_mode_e   : per-channel edge-detect mode encoding (2 bits/channel)
//   - DEBOUNCE_CYCLES_50MHZ / DEBOUNCE_CYCLES_SIM : debounce lengths for
//     hardware (10 ms at 50 MHz) and for short simulations
//   - edge_qualifies : decides whether a rise/fall matches a channel mode
// ---------------------------------------------------------------------------
package gpio_pkg;

    typedef enum logic [1:0] {
        MODE_NONE = 2'b00,
        MODE_RISE = 2'b01,
        MODE_FALL = 2'b10,
        MODE_BOTH = 2'b11
    } edge_mode_e;

    localparam int DEBOUNCE_CYCLES_50MHZ = 500000;
    localparam int DEBOUNCE_CYCLES_SIM   = 4;

    function automatic logic edge_qualifies(input logic [1:0] mode,
                                            input logic       rise,
                                            input logic       fall);
        logic want_rise;
        logic want_fall;
        want_rise = (mode == MODE_RISE) || (mode == MODE_BOTH);
        want_fall = (mode == MODE_FALL) || (mode == MODE_BOTH);
        return (rise && want_rise) || (fall && want_fall);
    endfunction

endpackage

// File: rtl/gpio_debounce.sv
// ---------------------------------------------------------------------------
// gpio_debounce
// Single-bit input conditioner: 2-flop synchroniser followed by a debounce
// filter. The synchronised level must differ from the clean level for
// DEBOUNCE_CYCLES consecutive clocks before it is accepted.
//   clk    in  system clock
//   rst    in  asynchronous active-high reset
//   pin    in  raw asynchronous pin
//   clean  out debounced level (registered)
//   accept out high in the cycle before clean toggles, i.e. clean will take
//              the new value at the coming clock edge (lets the parent
//              register an event pulse aligned with the new clean level)
// ---------------------------------------------------------------------------
module gpio_debounce
    import gpio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic clean,
    output logic accept
);

    localparam int DCNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);

    logic              sync0_q, sync0_d;
    logic              sync1_q, sync1_d;
    logic              clean_q, clean_d;
    logic [DCNT_W-1:0] dcnt_q,  dcnt_d;

    always_comb begin
        sync0_d = pin;
        sync1_d = sync0_q;
        clean_d = clean_q;
        dcnt_d  = '0;
        accept  = 1'b0;
        if (sync1_q == clean_q) begin
            // Agreement restarts the count, so any shorter glitch is lost.
            dcnt_d = '0;
        end else if (dcnt_q == DCNT_LAST) begin
            clean_d = sync1_q;
            dcnt_d  = '0;
            accept  = 1'b1;
        end else begin
            dcnt_d = dcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync0_q <= 1'b0;
            sync1_q <= 1'b0;
            clean_q <= 1'b0;
            dcnt_q  <= '0;
        end else begin
            sync0_q <= sync0_d;
            sync1_q <= sync1_d;
            clean_q <= clean_d;
            dcnt_q  <= dcnt_d;
        end
    end

    assign clean = clean_q;

endmodule

// File: rtl/gpio_in_capture.sv
// ---------------------------------------------------------------------------
// gpio_in_capture
// GPIO input front end: per channel synchroniser + debounce (gpio_debounce),
// mode-selectable edge detection, sticky write-1-to-clear event flags and
// saturating event counters, plus a channel-select counter mux.
//   CLOCK_50    in  system clock (50 MHz)
//   Reset       in  asynchronous active-high reset
//   gpio_in     in  raw pin inputs, WIDTH bits
//   edge_mode   in  2 bits per channel: 00 none, 01 rise, 10 fall, 11 both
//   clear       in  write-1-to-clear for event_flags[i] and counter i
//   sel         in  channel whose counter drives sel_count
//   gpio_clean  out debounced levels
//   event_pulse out one-cycle pulse per qualifying edge, aligned with the
//                   first cycle gpio_clean shows the new level
//   event_flags out sticky event flags
//   sel_count   out counter of channel sel (0 if sel >= WIDTH)
//   any_event   out OR of event_flags
// ---------------------------------------------------------------------------
module gpio_in_capture
    import gpio_pkg::*;
#(
    parameter int WIDTH           = 32,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ,
    parameter int CNT_W           = 16
) (
    input  logic                                       CLOCK_50,
    input  logic                                       Reset,
    input  logic [WIDTH-1:0]                           gpio_in,
    input  logic [2*WIDTH-1:0]                         edge_mode,
    input  logic [WIDTH-1:0]                           clear,
    input  logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0] sel,
    output logic [WIDTH-1:0]                           gpio_clean,
    output logic [WIDTH-1:0]                           event_pulse,
    output logic [WIDTH-1:0]                           event_flags,
    output logic [CNT_W-1:0]                           sel_count,
    output logic                                       any_event
);

    localparam int SEL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] accept;
    logic [WIDTH-1:0] qual;

    logic [WIDTH-1:0] pulse_q, pulse_d;
    logic [WIDTH-1:0] flags_q, flags_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    for (genvar g = 0; g < WIDTH; g++) begin : g_chan
        gpio_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk   (CLOCK_50),
            .rst   (Reset),
            .pin   (gpio_in[g]),
            .clean (gpio_clean[g]),
            .accept(accept[g])
        );
    end

    // The edge is judged from the clean level about to be replaced, using
    // the mode present on this same edge, so the pulse/flag/counter all
    // register together with the new gpio_clean value.
    always_comb begin
        qual = '0;
        for (int i = 0; i < WIDTH; i++) begin
            qual[i] = edge_qualifies(edge_mode[2*i +: 2],
                                     accept[i] & ~gpio_clean[i],
                                     accept[i] &  gpio_clean[i]);
        end
    end

    always_comb begin
        pulse_d = qual;
        // Set wins over a simultaneous clear.
        flags_d = (flags_q & ~clear) | qual;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (clear[i]) begin
                cnt_d[i] = CNT_W'(qual[i]);
            end else if (qual[i] && (cnt_q[i] != CNT_MAX)) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            pulse_q <= '0;
            flags_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            pulse_q <= pulse_d;
            flags_q <= flags_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Compare-based select: out-of-range sel values match no channel.
    always_comb begin
        sel_count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (sel == SEL_W'(i)) begin
                sel_count = cnt_q[i];
            end
        end
    end

    assign event_pulse = pulse_q;
    assign event_flags = flags_q;
    assign any_event   = |flags_q;

endmodule

// File: doc/gpio_in_capture.md
Name: gpio_in_capture

Overview:
- Parametrised GPIO input front end for the DE-series 40-pin header. Sits between the raw GPIO pins and user logic.
- Per channel it provides:
  - 2-flop synchroniser
  - debounce filter
  - edge detector, with a per-channel mode
  - sticky event flag with write-1-to-clear
  - saturating event counter
- A channel-select mux exposes one counter, e.g. for HEX display logic.

Parameters:
- WIDTH, 32: number of GPIO input channels (1..32).
- DEBOUNCE_CYCLES, 500000: consecutive CLOCK_50 cycles an input must differ from the clean value before it is accepted. 10 ms at 50 MHz. Must be ≥1.
- CNT_W, 16: width of each per-channel event counter.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- Reset  in  1  asynchronous, active-high reset.
- gpio_in  in  WIDTH  raw asynchronous pin inputs.
- edge_mode  in  2*WIDTH  per-channel mode, bits [2i+1:2i]: 00 none, 01 rise, 10 fall, 11 both.
- clear  in  WIDTH  write-1-to-clear; clear[i] clears event_flags[i] and counter i.
- sel  in  max(1,$clog2(WIDTH))  channel select for sel_count.
- gpio_clean  out  WIDTH  debounced level.
- event_pulse  out  WIDTH  one-cycle pulse per qualifying edge.
- event_flags  out  WIDTH  sticky event flags.
- sel_count  out  CNT_W  counter of channel sel.
- any_event  out  1  OR of event_flags.

Behaviour:
- **Reset (async, active-high):**
  - Clears sync0, sync1, clean, debounce counters, event_pulse, event_flags and event counters to 0.
  - All outputs read 0 while Reset is high.
  - Reset asserted mid-debounce abandons the count.
- **Synchroniser:** gpio_in → sync0 → sync1, one flop each per channel.
- **Debounce, per channel, each rising edge:**
  - If sync1 == clean: dcnt ← 0.
  - Else if dcnt == DEBOUNCE_CYCLES-1: clean ← sync1, dcnt ← 0.
  - Else: dcnt ← dcnt+1.
  - dcnt width is $clog2(DEBOUNCE_CYCLES+1).
- **Debounce latency:**
  - A pin change held stable before edge 0 appears on gpio_clean after edge 1+DEBOUNCE_CYCLES.
  - That is DEBOUNCE_CYCLES+2 edges.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles, as seen at sync1, is rejected and the count restarts from 0.
- **Edge detect:**
  - rise = clean 0→1 at this edge; fall = 1→0.
  - event_pulse[i] is registered and high for exactly the one cycle in which gpio_clean[i] shows its new value, when the edge matches edge_mode[i].
  - edge_mode is sampled at the edge on which clean changes. A mode change takes effect from the next edge; there is no retroactive event.
- **Flags:**
  - event_flags[i] ← (event_flags[i] & ~clear[i]) | qualifying_edge[i].
  - Simultaneous event and clear: the flag stays 1 (set wins).
- **Counters:**
  - Counter i increments on each qualifying edge and saturates at 2^CNT_W-1; it never wraps.
  - clear[i] zeroes the counter.
  - Simultaneous clear and event leaves the counter at 1.
- **sel_count:** combinational mux of counter[sel]. If sel ≥ WIDTH, output 0.
- **any_event:** combinational OR of the registered event_flags.
- **Post-reset edges:** a pin already high when Reset releases is treated as a real 0→1 transition. It produces a rise event DEBOUNCE_CYCLES+2 edges after release.
- **Channel independence:** channels are fully independent. Simultaneous edges on several channels are each handled in the same cycle.

Decomposition:
- Shared package gpio_pkg holds:
  - Mode encodings MODE_NONE, MODE_RISE, MODE_FALL, MODE_BOTH.
  - Default DEBOUNCE_CYCLES constant for 50 MHz (500000) and a simulation value (4).
- One sub-module, gpio_debounce (single bit: sync chain, dcnt, clean), instantiated WIDTH times by generate.
- Edge detection, flags, counters and the mux stay in gpio_in_capture.

Test Plan (WIDTH=8, DEBOUNCE_CYCLES=4, CNT_W=4):
1. gpio_in[0] 0→1 held, mode 01 → gpio_clean[0]=1 exactly 6 edges later; event_pulse[0] high 1 cycle in that same cycle; event_flags[0]=1; sel=0 gives sel_count=1; any_event=1.
2. Glitch high on gpio_in[1] for 3 cycles, then low, mode 11 → gpio_clean[1] stays 0; no pulse; flags and count stay 0.
3. Channel 2, mode 10, input toggled 0→1→0 with each level held 10 cycles → one event only (the fall); counter=1; then mode 01 and toggle again → counter=2.
4. Channel 3, mode 11, 20 stable toggles → counter saturates at 15; clear[3] for 1 cycle → flag 0, count 0.
5. Assert clear[4] in the same cycle as a qualifying edge on channel 4 → event_flags[4]=1, counter 4 = 1.
6. Assert Reset asynchronously mid-debounce with gpio_in=8'hFF → all outputs 0 immediately; after release, all gpio_clean=8'hFF and event_pulse=8'hFF (mode 11) 6 edges later.
